// File: rtl/feature_loader_pkg.sv
// Shared constants for the feature loader: stream geometry, selected feature
// indices and the loader FSM state encoding.
package feature_loader_pkg;

    localparam int N_FEAT = 279;
    localparam int N_SEL  = 45;
    localparam int IDX_W  = 9;
    localparam int SLOT_W = 6;

    localparam logic [IDX_W-1:0] SEL_IDX [0:N_SEL-1] = '{
        9'd0,   9'd2,   9'd5,   9'd9,   9'd10,  9'd12,  9'd13,  9'd50,  9'd55,
        9'd74,  9'd91,  9'd124, 9'd139, 9'd147, 9'd164, 9'd170, 9'd171, 9'd175,
        9'd180, 9'd184, 9'd186, 9'd190, 9'd195, 9'd199, 9'd205, 9'd209, 9'd216,
        9'd221, 9'd222, 9'd235, 9'd236, 9'd240, 9'd246, 9'd251, 9'd255, 9'd256,
        9'd257, 9'd258, 9'd261, 9'd264, 9'd265, 9'd271, 9'd274, 9'd275, 9'd276
    };

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/feature_loader_sel_lut.sv
// Combinational lookup: byte index -> {hit, destination slot} for the
// selected-feature table.
module feat_sel_lut
    import feature_loader_pkg::*;
(
    input  logic [IDX_W-1:0]  index,
    output logic              hit,
    output logic [SLOT_W-1:0] slot
);

    // Parallel compare against every table entry; entries are unique.
    always_comb begin
        hit  = 1'b0;
        slot = {SLOT_W{1'b0}};
        for (int k = 0; k < N_SEL; k++) begin
            hit  = hit | (index == SEL_IDX[k]);
            slot = (index == SEL_IDX[k]) ? SLOT_W'(k) : slot;
        end
    end

endmodule

// File: rtl/feature_loader.sv
// Streams one sample of feature bytes, captures the selected ones into
// feat_vec and holds the result until the downstream side takes it.
module feature_loader
    import feature_loader_pkg::*;
#(
    parameter int N_FEAT = feature_loader_pkg::N_FEAT,
    parameter int N_SEL  = feature_loader_pkg::N_SEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic [N_SEL*8-1:0] feat_vec,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     index_r;
    logic [IDX_W-1:0]     index_nxt_s;
    logic [N_SEL*8-1:0]   feat_vec_r;
    logic                 err_r;
    logic                 err_nxt_s;
    logic                 wr_en_s;
    logic                 accept_s;
    logic                 hit_s;
    logic [SLOT_W-1:0]    slot_s;

    feat_sel_lut u_lut (
        .index (index_r),
        .hit   (hit_s),
        .slot  (slot_s)
    );

    assign accept_s = s_valid & s_ready;

    // Next-state, index and error-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        index_nxt_s = index_r;
        err_nxt_s   = 1'b0;
        wr_en_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (accept_s) begin
                    wr_en_s = hit_s;
                    if (s_last) begin
                        index_nxt_s = {IDX_W{1'b0}};
                        if (index_r == LAST_IDX) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            err_nxt_s = 1'b1;
                        end
                    end else if (index_r == LAST_IDX) begin
                        // Sample overran its length: drop bytes until the next s_last.
                        index_nxt_s = {IDX_W{1'b0}};
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        index_nxt_s = index_r + 9'd1;
                    end
                end else begin
                    index_nxt_s = index_r;
                end
            end
            ST_HOLD: begin
                if (feat_ready) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (accept_s && s_last) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                index_nxt_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, index, captured features and error pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_LOAD;
            index_r    <= {IDX_W{1'b0}};
            feat_vec_r <= {(N_SEL*8){1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            index_r <= index_nxt_s;
            err_r   <= err_nxt_s;
            if (wr_en_s) begin
                feat_vec_r[int'(slot_s)*8 +: 8] <= s_data;
            end else begin
                feat_vec_r <= feat_vec_r;
            end
        end
    end

    assign s_ready    = (state_r != ST_HOLD);
    assign feat_valid = (state_r == ST_HOLD);
    assign feat_vec   = feat_vec_r;
    assign err        = err_r;

endmodule
